// File: rtl/sti_receiver.sv
// STI serial receiver: rebuilds a 16-bit payload from an 8/16/24/32-bit frame
// qualified by si_valid, and reports truncated frames and nonzero fill bits.
module sti_receiver #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              si_data,
  input  logic              si_valid,
  input  logic [1:0]        cfg_length,
  input  logic              cfg_msb,
  input  logic              cfg_low,
  input  logic              cfg_fill,
  output logic [DATA_W-1:0] po_data,
  output logic              po_valid,
  output logic              po_fill_err,
  output logic              po_err,
  output logic [7:0]        po_count
);

  typedef enum logic {IDLE, RECV} state_t;

  state_t            state_reg;
  logic [CNT_W-1:0]  k_reg;
  logic [1:0]        len_reg;
  logic              msb_reg;
  logic              low_reg;
  logic              fsel_reg;
  logic [DATA_W-1:0] payload_reg;
  logic [DATA_W-1:0] payload_next;
  logic              fill_err_reg;
  logic              fill_err_next;

  logic              idle;
  logic [1:0]        eff_len;
  logic              eff_msb;
  logic              eff_low;
  logic              eff_fill;
  logic [CNT_W-1:0]  k_cur;
  logic [CNT_W-1:0]  n_bits;
  logic [CNT_W-1:0]  data_start;
  logic              wide;
  logic              is_data;
  logic [3:0]        d;
  logic [3:0]        pos;
  logic              last;

  // The first bit of a frame is decoded with the live cfg; later bits use the shadow copy.
  always_comb begin
    idle       = (state_reg == IDLE);
    eff_len    = idle ? cfg_length : len_reg;
    eff_msb    = idle ? cfg_msb    : msb_reg;
    eff_low    = idle ? cfg_low    : low_reg;
    eff_fill   = idle ? cfg_fill   : fsel_reg;
    k_cur      = idle ? '0 : k_reg;
    n_bits     = CNT_W'({eff_len, 3'b000}) + CNT_W'(8);
    wide       = eff_len[1];
    data_start = (wide && (eff_fill != eff_msb)) ? n_bits - CNT_W'(16) : '0;
    is_data    = !wide || ((k_cur >= data_start) && (k_cur < data_start + CNT_W'(16)));
    d          = k_cur[3:0] - data_start[3:0];
    if (eff_len == 2'b00) begin
      pos = {eff_low, eff_msb ? 3'd7 - d[2:0] : d[2:0]};
    end else begin
      pos = eff_msb ? 4'd15 - d : d;
    end
    last = (k_cur == n_bits - CNT_W'(1));

    payload_next = idle ? '0 : payload_reg;
    if (is_data) begin
      payload_next[pos] = si_data;
    end
    fill_err_next = (idle ? 1'b0 : fill_err_reg) | (si_data & ~is_data);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      k_reg        <= '0;
      len_reg      <= '0;
      msb_reg      <= 1'b0;
      low_reg      <= 1'b0;
      fsel_reg     <= 1'b0;
      payload_reg  <= '0;
      fill_err_reg <= 1'b0;
      po_data      <= '0;
      po_valid     <= 1'b0;
      po_fill_err  <= 1'b0;
      po_err       <= 1'b0;
      po_count     <= '0;
    end else begin
      po_valid <= 1'b0;
      po_err   <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (si_valid) begin
            len_reg      <= cfg_length;
            msb_reg      <= cfg_msb;
            low_reg      <= cfg_low;
            fsel_reg     <= cfg_fill;
            payload_reg  <= payload_next;
            fill_err_reg <= fill_err_next;
            state_reg    <= RECV;
            k_reg        <= CNT_W'(1);
          end
        end
        RECV: begin
          if (si_valid) begin
            payload_reg  <= payload_next;
            fill_err_reg <= fill_err_next;
            if (last) begin
              // Returning to IDLE lets a following si_valid bit start the next frame with no gap.
              po_data     <= payload_next;
              po_fill_err <= fill_err_next;
              po_valid    <= 1'b1;
              po_count    <= po_count + 8'd1;
              state_reg   <= IDLE;
              k_reg       <= '0;
            end else begin
              k_reg <= k_reg + CNT_W'(1);
            end
          end else begin
            po_err    <= 1'b1;
            state_reg <= IDLE;
            k_reg     <= '0;
          end
        end
        default: begin
          state_reg <= IDLE;
          k_reg     <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sti_receiver.sv
// Scoreboard bench for sti_receiver: frames are sent serially, expected words are
// queued at send time and checked as po_valid pulses arrive.
module tb_sti_receiver;

  logic        clk = 1'b0;
  logic        reset;
  logic        si_data;
  logic        si_valid;
  logic [1:0]  cfg_length;
  logic        cfg_msb;
  logic        cfg_low;
  logic        cfg_fill;
  logic [15:0] po_data;
  logic        po_valid;
  logic        po_fill_err;
  logic        po_err;
  logic [7:0]  po_count;

  sti_receiver #(.DATA_W(16), .CNT_W(6)) dut (
    .clk        (clk),
    .reset      (reset),
    .si_data    (si_data),
    .si_valid   (si_valid),
    .cfg_length (cfg_length),
    .cfg_msb    (cfg_msb),
    .cfg_low    (cfg_low),
    .cfg_fill   (cfg_fill),
    .po_data    (po_data),
    .po_valid   (po_valid),
    .po_fill_err(po_fill_err),
    .po_err     (po_err),
    .po_count   (po_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] data;
    logic        fe;
    logic [7:0]  cnt;
  } exp_t;

  exp_t        sb_q[$];
  int          valid_cyc[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          err_seen = 0;
  int          exp_err = 0;
  logic [7:0]  model_count = 8'd0;
  logic [15:0] model_data = 16'd0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [15:0] rev16(input logic [15:0] v);
    logic [15:0] r;
    for (int i = 0; i < 16; i++) r[i] = v[15-i];
    return r;
  endfunction

  task automatic push_exp(input logic [15:0] data, input logic fe);
    exp_t e;
    model_count = model_count + 8'd1;
    model_data  = data;
    e.data = data;
    e.fe   = fe;
    e.cnt  = model_count;
    sb_q.push_back(e);
  endtask

  // stream[nbits-1] goes on the wire first; cfg is scrambled after the first bit.
  task automatic send_frame(input logic [1:0] len, input logic msb, input logic low,
                            input logic fill, input logic [31:0] stream,
                            input int nbits, input bit keep);
    for (int j = 0; j < nbits; j++) begin
      if (j == 0) begin
        cfg_length = len;
        cfg_msb    = msb;
        cfg_low    = low;
        cfg_fill   = fill;
      end else begin
        cfg_length = 2'($urandom);
        cfg_msb    = 1'($urandom);
        cfg_low    = 1'($urandom);
        cfg_fill   = 1'($urandom);
      end
      si_valid = 1'b1;
      si_data  = stream[nbits-1-j];
      @(posedge clk);
      #1;
    end
    if (!keep) begin
      si_valid = 1'b0;
      si_data  = 1'b0;
    end
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 200 && sb_q.size() != 0; i++) begin
      @(negedge clk);
      #1;
    end
    check_value("scoreboard_drain", sb_q.size(), 0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check_value({tag, "_data"},  po_data,     0);
    check_value({tag, "_valid"}, po_valid,    0);
    check_value({tag, "_fill"},  po_fill_err, 0);
    check_value({tag, "_err"},   po_err,      0);
    check_value({tag, "_count"}, po_count,    0);
  endtask

  exp_t mon_e;
  always @(negedge clk) begin
    if (!reset) begin
      if (po_valid) begin
        check_value("valid_err_exclusive", po_err, 0);
        valid_cyc.push_back(cyc);
        if (sb_q.size() == 0) begin
          check_value("unexpected_valid", 1, 0);
        end else begin
          mon_e = sb_q.pop_front();
          $display("rx frame: data=0x%04h fill_err=%b count=%0d", po_data, po_fill_err, po_count);
          check_value("po_data",     po_data,     mon_e.data);
          check_value("po_fill_err", po_fill_err, mon_e.fe);
          check_value("po_count",    po_count,    mon_e.cnt);
        end
      end
      if (po_err) begin
        err_seen++;
        $display("rx truncated frame: err pulse, data=0x%04h count=%0d", po_data, po_count);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion earlier");
    $fatal(1, "timeout");
  end

  initial begin
    int t0;
    int n;
    logic [15:0] p;
    logic m;

    reset = 1'b1; si_valid = 1'b0; si_data = 1'b0;
    cfg_length = 2'b00; cfg_msb = 1'b0; cfg_low = 1'b0; cfg_fill = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_outputs_zero("reset");
    @(posedge clk);
    #1;

    // 8-bit frames: MSB-first to low byte, LSB-first to high byte, MSB-first to high byte
    push_exp(16'h00A5, 1'b0); send_frame(2'b00, 1'b1, 1'b0, 1'b0, 32'hA5, 8, 0);
    push_exp(16'hA500, 1'b0); send_frame(2'b00, 1'b0, 1'b1, 1'b0, 32'hA5, 8, 0);
    push_exp(16'h5A00, 1'b0); send_frame(2'b00, 1'b1, 1'b1, 1'b0, 32'h5A, 8, 0);

    // 32-bit, data first then fill; clean and with last fill bit set
    push_exp(16'h1234, 1'b0); send_frame(2'b11, 1'b1, 1'b0, 1'b1, 32'h1234_0000, 32, 0);
    push_exp(16'h1234, 1'b1); send_frame(2'b11, 1'b1, 1'b0, 1'b1, 32'h1234_0001, 32, 0);
    // 24-bit MSB-first, fill first; 32-bit LSB-first, data first with a fill bit set
    push_exp(16'h7E81, 1'b0); send_frame(2'b10, 1'b1, 1'b0, 1'b0, {8'h00, 16'h7E81}, 24, 0);
    push_exp(16'h5555, 1'b1); send_frame(2'b11, 1'b0, 1'b0, 1'b0, {rev16(16'h5555), 16'h8000}, 32, 0);
    wait_drain();

    // back-to-back 24-bit then 16-bit frame
    t0 = cyc;
    n  = valid_cyc.size();
    push_exp(16'hBEEF, 1'b0);
    push_exp(16'h0F0F, 1'b0);
    send_frame(2'b10, 1'b0, 1'b0, 1'b1, {8'h00, rev16(16'hBEEF)}, 24, 1);
    send_frame(2'b01, 1'b1, 1'b0, 1'b0, 32'h0F0F, 16, 0);
    wait_drain();
    check_value("b2b_pulses", valid_cyc.size() - n, 2);
    if (valid_cyc.size() - n == 2) begin
      check_value("b2b_first_gap",  valid_cyc[n] - t0, 24);
      check_value("b2b_second_gap", valid_cyc[n+1] - valid_cyc[n], 16);
    end

    // truncated 16-bit frame, then a good one
    exp_err++;
    send_frame(2'b01, 1'b1, 1'b0, 1'b0, 32'h3FF, 10, 0);
    repeat (3) @(negedge clk);
    #1;
    check_value("trunc_err_pulses", err_seen, exp_err);
    check_value("trunc_data_held",  po_data,  model_data);
    check_value("trunc_count_held", po_count, model_count);
    push_exp(16'hC3A5, 1'b0); send_frame(2'b01, 1'b1, 1'b0, 1'b0, 32'hC3A5, 16, 0);
    wait_drain();

    // reset in the middle of a 32-bit frame
    send_frame(2'b11, 1'b1, 1'b0, 1'b1, 32'hFFF, 12, 1);
    reset = 1'b1; si_valid = 1'b0; si_data = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;
    model_count = 8'd0;
    model_data  = 16'd0;
    @(negedge clk);
    check_outputs_zero("midreset");
    repeat (3) @(negedge clk);
    check_value("midreset_no_err", err_seen, exp_err);
    @(posedge clk);
    #1;

    // 256 good 16-bit frames, some back-to-back, count wraps to 0
    for (int i = 0; i < 256; i++) begin
      p = 16'($urandom);
      m = 1'($urandom_range(0, 1));
      push_exp(p, 1'b0);
      send_frame(2'b01, m, 1'b0, 1'b0, {16'h0000, (m ? p : rev16(p))}, 16, (i % 3) != 0);
    end
    wait_drain();
    check_value("count_wrap", po_count, model_count);
    check_value("total_err_pulses", err_seen, exp_err);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
